// File: rtl/tcp_tx_ctrl_arbiter.sv
// ---------------------------------------------------------------------------
// tcp_pkg / tcp_tx_ctrl_arbiter
//
// The package holds the tx_ctrl command type shared by the per-socket state
// managers and the TCP transmit packet generator.
//
// The arbiter shares one TCP transmit packet generator between NUM_SOCKETS
// socket state managers. It grants one socket at a time in round-robin order
// and holds the grant until the generator acks, the requester withdraws, or a
// watchdog expires. Each grant is followed by a one-cycle RELEASE gap.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_enable              1 = arbitrate, 0 = drop grants and stay idle
//   i_req_tx_ctrl[]       per-socket command
//   i_req_tx_ctrl_valid   per-socket request valid
//   o_req_tx_ctrl_ack     per-socket ack (one-hot or zero)
//   o_tx_ctrl             command to the generator
//   o_tx_ctrl_valid       command valid
//   o_tx_sock_id          socket index of the current command
//   i_tx_ctrl_ack         generator accepted the command
//   o_timeout             sticky per-socket watchdog flags
//   i_timeout_clr         write-1-to-clear for o_timeout
//   o_abort_count         saturating count of requests withdrawn while granted
// ---------------------------------------------------------------------------
package tcp_pkg;

  typedef enum logic [2:0] {
    TX_CTRL_NOP     = 3'd0,
    TX_CTRL_SYN     = 3'd1,
    TX_CTRL_SYN_ACK = 3'd2,
    TX_CTRL_ACK     = 3'd3,
    TX_CTRL_FIN     = 3'd4,
    TX_CTRL_FIN_ACK = 3'd5,
    TX_CTRL_RST     = 3'd6,
    TX_CTRL_PSH_ACK = 3'd7
  } tx_ctrl_t;

endpackage

module tcp_tx_ctrl_arbiter #(
  parameter int unsigned NUM_SOCKETS    = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_enable,
  input  tcp_pkg::tx_ctrl_t              i_req_tx_ctrl [NUM_SOCKETS],
  input  logic [NUM_SOCKETS-1:0]         i_req_tx_ctrl_valid,
  output logic [NUM_SOCKETS-1:0]         o_req_tx_ctrl_ack,
  output tcp_pkg::tx_ctrl_t              o_tx_ctrl,
  output logic                           o_tx_ctrl_valid,
  output logic [$clog2(NUM_SOCKETS)-1:0] o_tx_sock_id,
  input  logic                           i_tx_ctrl_ack,
  output logic [NUM_SOCKETS-1:0]         o_timeout,
  input  logic [NUM_SOCKETS-1:0]         i_timeout_clr,
  output logic [7:0]                     o_abort_count
);

  localparam int unsigned SW = $clog2(NUM_SOCKETS);
  localparam int unsigned WW = $clog2(TIMEOUT_CYCLES);
  localparam logic [WW-1:0] WDOG_LAST = WW'(TIMEOUT_CYCLES - 1);
  localparam logic [SW-1:0] SOCK_LAST = SW'(NUM_SOCKETS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT,
    ST_RELEASE
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [SW-1:0]          rr_ptr;
  logic [SW-1:0]          grant_idx;
  logic [SW-1:0]          grant_after;
  logic [WW-1:0]          wdog;
  logic [NUM_SOCKETS-1:0] timeout_q;
  logic [7:0]             abort_cnt;

  logic                   pick_found;
  logic [SW-1:0]          pick_idx;

  logic                   in_grant;
  logic                   grant_req_valid;
  logic                   tx_valid;
  logic                   ev_ack;
  logic                   ev_abort;
  logic                   ev_timeout;
  logic                   ev_release;
  logic                   start_grant;

  // -------------------------------------------------------------------------
  // Round-robin pick: first valid request at or after rr_ptr, wrapping.
  // -------------------------------------------------------------------------
  always_comb begin : rr_pick
    int unsigned   cand;
    logic [SW-1:0] cand_idx;
    cand       = 0;
    cand_idx   = '0;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int unsigned i = 0; i < NUM_SOCKETS; i++) begin
      cand = 32'(rr_ptr) + i;
      if (cand >= NUM_SOCKETS) begin
        cand = cand - NUM_SOCKETS;
      end
      cand_idx = SW'(cand);
      if (!pick_found && i_req_tx_ctrl_valid[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Grant-phase events. Ack requires a live valid and abort requires a
  // dropped valid, so they are exclusive; the watchdog only fires when
  // neither happened, which gives ack > abort > timeout.
  // -------------------------------------------------------------------------
  assign in_grant        = (state == ST_GRANT) && i_enable && !i_rst;
  assign grant_req_valid = i_req_tx_ctrl_valid[grant_idx];
  assign tx_valid        = in_grant && grant_req_valid;
  assign ev_ack          = tx_valid && i_tx_ctrl_ack;
  assign ev_abort        = in_grant && !grant_req_valid;
  assign ev_timeout      = tx_valid && !i_tx_ctrl_ack && (wdog == WDOG_LAST);
  assign ev_release      = ev_ack || ev_abort || ev_timeout;
  assign start_grant     = (state == ST_IDLE) && i_enable && pick_found;
  assign grant_after     = (grant_idx == SOCK_LAST) ? '0 : grant_idx + 1'b1;

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (start_grant) begin
          state_nxt = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (ev_release) begin
          state_nxt = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
    if (!i_enable) begin
      state_nxt = ST_IDLE;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: outputs. Everything outside an enabled GRANT is NOP/invalid.
  // -------------------------------------------------------------------------
  always_comb begin
    o_tx_ctrl         = tcp_pkg::TX_CTRL_NOP;
    o_tx_ctrl_valid   = 1'b0;
    o_tx_sock_id      = '0;
    o_req_tx_ctrl_ack = '0;
    if ((state == ST_GRANT) && !i_rst) begin
      o_tx_ctrl                    = i_req_tx_ctrl[grant_idx];
      o_tx_sock_id                 = grant_idx;
      o_tx_ctrl_valid              = tx_valid;
      o_req_tx_ctrl_ack[grant_idx] = ev_ack;
    end
  end

  // -------------------------------------------------------------------------
  // Grant index, round-robin pointer and watchdog
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rr_ptr    <= '0;
      grant_idx <= '0;
      wdog      <= '0;
    end else begin
      if (start_grant) begin
        grant_idx <= pick_idx;
        wdog      <= '0;
      end else if (in_grant && (wdog != WDOG_LAST)) begin
        wdog <= wdog + 1'b1;
      end
      if (ev_release) begin
        rr_ptr <= grant_after;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Sticky timeout flags (set wins over clear) and abort counter
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      timeout_q <= '0;
      abort_cnt <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_SOCKETS; i++) begin
        if (ev_timeout && (grant_idx == SW'(i))) begin
          timeout_q[i] <= 1'b1;
        end else if (i_timeout_clr[i]) begin
          timeout_q[i] <= 1'b0;
        end
      end
      if (ev_abort && (abort_cnt != 8'hFF)) begin
        abort_cnt <= abort_cnt + 8'd1;
      end
    end
  end

  assign o_timeout     = timeout_q;
  assign o_abort_count = abort_cnt;

endmodule

// File: doc/tcp_tx_ctrl_arbiter.md
Name: tcp_tx_ctrl_arbiter

Overview:
Shares the single TCP transmit packet generator between NUM_SOCKETS per-socket TCP state managers. Each state manager presents a tx_ctrl command (SYN, ACK, FIN, …) with valid/ack handshake. The arbiter grants one socket at a time, round-robin, holds the grant until the generator acks, and reports the granted socket index. A watchdog releases the generator from a hung grant and flags the socket.

Parameters:
NUM_SOCKETS, 4, number of requesting state managers (2..16)
TIMEOUT_CYCLES, 1024, max cycles a grant may wait for i_tx_ctrl_ack before forced release (>=2)

Ports:
i_clk  input  1  clock
i_rst  input  1  synchronous reset, active-high
i_enable  input  1  1 = arbitrate; 0 = idle, all grants dropped
i_req_tx_ctrl  input  NUM_SOCKETS x tcp_pkg::tx_ctrl_t  per-socket command
i_req_tx_ctrl_valid  input  NUM_SOCKETS  per-socket request valid
o_req_tx_ctrl_ack  output  NUM_SOCKETS  per-socket ack (one-hot or zero)
o_tx_ctrl  output  tcp_pkg::tx_ctrl_t  command to generator
o_tx_ctrl_valid  output  1  command valid
o_tx_sock_id  output  $clog2(NUM_SOCKETS)  socket index of current command
i_tx_ctrl_ack  input  1  generator accepted command
o_timeout  output  NUM_SOCKETS  sticky per-socket timeout flags
i_timeout_clr  input  NUM_SOCKETS  W1C clear for o_timeout
o_abort_count  output  8  saturating count of requests withdrawn while granted

Behaviour:
- States: IDLE, GRANT, RELEASE.
- Reset (i_rst=1): state IDLE, rr pointer 0, grant index 0, watchdog 0, o_timeout 0, o_abort_count 0. Outputs in reset: o_tx_ctrl = TX_CTRL_NOP, o_tx_ctrl_valid 0, o_req_tx_ctrl_ack 0, o_tx_sock_id 0. Reset mid-GRANT discards the grant with no ack.
- IDLE: if i_enable and any valid, pick the first valid index at or after the rr pointer (wrapping modulo NUM_SOCKETS). Register it as the grant and go to GRANT. The decision is registered: valid at cycle t gives o_tx_ctrl_valid at t+1.
- GRANT:
  - o_tx_ctrl = i_req_tx_ctrl[grant] and o_tx_sock_id = grant.
  - o_tx_ctrl_valid = i_req_tx_ctrl_valid[grant], combinational pass-through.
  - o_req_tx_ctrl_ack[grant] = i_tx_ctrl_ack & o_tx_ctrl_valid, same cycle, combinational. All other ack bits are 0.
  - Ack: go to RELEASE and set rr pointer = grant+1 (wrap).
  - Requester drops valid before ack (abort): go to RELEASE, advance the pointer, increment o_abort_count (saturates at 255). No ack is issued.
  - Watchdog increments each GRANT cycle. If it reaches TIMEOUT_CYCLES-1 with no ack: set o_timeout[grant], go to RELEASE, advance the pointer.
  - Precedence on the same cycle: ack > abort > timeout.
  - The watchdog clears on entry to GRANT.
- RELEASE: one cycle, outputs NOP/invalid, then IDLE. This guarantees the acked requester has deasserted valid or presented its next command before re-arbitration. Minimum command spacing is therefore 3 cycles.
- i_enable=0: the next state is forced to IDLE from any state and no new grants are made. o_tx_ctrl_valid is forced 0 combinationally in that cycle. The rr pointer, o_timeout and o_abort_count are retained.
- o_timeout: the set has priority over i_timeout_clr for the same bit in the same cycle.
- i_tx_ctrl_ack while o_tx_ctrl_valid=0 is ignored.
- Commands are not buffered. A requester must hold its command stable while valid is high.

Test Plan:
- Single request: socket 2 valid SYN at cycle 0. Required: o_tx_ctrl_valid=1, o_tx_sock_id=2, o_tx_ctrl=SYN at cycle 1. Ack at cycle 3 gives o_req_tx_ctrl_ack=4'b0100 at cycle 3. Next grant goes to the lowest valid index ≥3 after RELEASE.
- Round-robin: sockets 0,1,3 held valid with ack on first valid cycle each time. Required grant order 0,1,3,0,1,3 with 3-cycle spacing, and o_req_tx_ctrl_ack one-hot each time.
- Timeout (TIMEOUT_CYCLES=8): socket 1 valid, no ack. Required: grant dropped after 8 GRANT cycles, o_timeout=4'b0010 sticky, next grant to socket 2 if it is valid. An i_timeout_clr=4'b0010 pulse clears the flag.
- Abort: socket 0 granted, then drops valid before ack. Required: o_tx_ctrl_valid low the same cycle, no ack, o_abort_count 0→1, pointer advances to 1.
- Ack and timeout on the same cycle: ack wins. o_req_tx_ctrl_ack asserted and o_timeout stays 0.
- Reset/enable mid-grant:
  - i_rst during GRANT: required all outputs idle next cycle, pointer 0, flags cleared.
  - i_enable=0 during GRANT: o_tx_ctrl_valid=0 that cycle, IDLE next cycle, flags retained, no grant while disabled.
